// File: rtl/dmem_subword_if.sv
// CPU-to-data-memory bus: request fields from the MEM stage and the same-cycle load response.
// The request and response are combinational, with no handshake, because the MEM stage has a fixed latency.
interface dmem_subword_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic        mem_w;
  logic        mem_r;
  logic [2:0]  dm_type;
  logic [31:0] dout;
  logic        misalign;

  modport master (
    output addr, din, mem_w, mem_r, dm_type,
    input  dout, misalign
  );

  modport slave (
    input  addr, din, mem_w, mem_r, dm_type,
    output dout, misalign
  );
endinterface

// File: rtl/dmem_subword.sv
// Data memory with byte/halfword/word access, sign/zero-extended loads, misalignment detection, sticky fault capture and load/store counters.
// Loads are combinational in the request cycle and stores commit on the next edge; the block never stalls.
module dmem_subword #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  dmem_subword_if.slave    bus,
  input  logic             i_err_clr,
  output logic             o_err,
  output logic [31:0]      o_err_addr,
  output logic [CNT_W-1:0] o_ld_cnt,
  output logic [CNT_W-1:0] o_st_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_HU = 3'b010;
  localparam logic [2:0] T_B  = 3'b011;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_mem [DEPTH];
  logic             r_err;
  logic [31:0]      r_err_addr;
  logic [CNT_W-1:0] r_ld_cnt;
  logic [CNT_W-1:0] r_st_cnt;

  logic             w_is_half;
  logic             w_is_byte;
  logic             w_misalign;
  logic             w_ld_ok;
  logic             w_st_ok;
  logic [AW-1:0]    w_idx;
  logic [1:0]       w_lane;
  logic [31:0]      w_rd_word;
  logic [15:0]      w_rd_half;
  logic [7:0]       w_rd_byte;
  logic [31:0]      w_wr_data;
  logic [3:0]       w_be;
  logic [31:0]      w_dout;

  always_comb begin
    w_is_half = (bus.dm_type == T_H) || (bus.dm_type == T_HU);
    w_is_byte = (bus.dm_type == T_B) || (bus.dm_type == T_BU);
    w_idx     = bus.addr[AW+1:2];
    w_lane    = bus.addr[1:0];

    // Codes 101-111 fall through to the word rule.
    w_misalign = 1'b0;
    if (bus.mem_r || bus.mem_w) begin
      if (w_is_half)      w_misalign = bus.addr[0];
      else if (!w_is_byte) w_misalign = (bus.addr[1:0] != 2'b00);
    end

    w_ld_ok = bus.mem_r && !w_misalign;
    w_st_ok = bus.mem_w && !w_misalign && !rst;
  end

  always_comb begin
    w_rd_word = r_mem[w_idx];
    w_rd_half = bus.addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    w_rd_byte = w_rd_word[{w_lane, 3'b000} +: 8];

    w_dout = 32'h0;
    if (w_ld_ok) begin
      case (bus.dm_type)
        T_H:     w_dout = {{16{w_rd_half[15]}}, w_rd_half};
        T_HU:    w_dout = {16'h0, w_rd_half};
        T_B:     w_dout = {{24{w_rd_byte[7]}}, w_rd_byte};
        T_BU:    w_dout = {24'h0, w_rd_byte};
        default: w_dout = w_rd_word;
      endcase
    end
  end

  always_comb begin
    w_wr_data = bus.din;
    w_be      = 4'b1111;
    if (w_is_half) begin
      w_wr_data = {bus.din[15:0], bus.din[15:0]};
      w_be      = bus.addr[1] ? 4'b1100 : 4'b0011;
    end else if (w_is_byte) begin
      w_wr_data = {4{bus.din[7:0]}};
      w_be      = 4'b0001 << w_lane;
    end
  end

  // The array is deliberately left out of reset; only the lanes that are enabled are written.
  always_ff @(posedge clk) begin
    if (w_st_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  // A fault on the same edge as err_clr wins and records the new address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
    end else if (w_misalign) begin
      r_err <= 1'b1;
      if (!r_err || i_err_clr) r_err_addr <= bus.addr;
    end else if (i_err_clr) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_cnt <= '0;
      r_st_cnt <= '0;
    end else begin
      if (w_ld_ok && (r_ld_cnt != {CNT_W{1'b1}})) r_ld_cnt <= r_ld_cnt + CNT_ONE;
      if (w_st_ok && (r_st_cnt != {CNT_W{1'b1}})) r_st_cnt <= r_st_cnt + CNT_ONE;
    end
  end

  assign bus.dout     = w_dout;
  assign bus.misalign = w_misalign;
  assign o_err        = r_err;
  assign o_err_addr   = r_err_addr;
  assign o_ld_cnt     = r_ld_cnt;
  assign o_st_cnt     = r_st_cnt;

endmodule

// File: doc/dmem_subword.md
Name: dmem_subword

Overview:
- Data-memory stage directly downstream of the pipelined CPU's MEM stage.
- Consumes the CPU's Addr_out, Data_out, mem_w, mem_r and the 3-bit DMType carried in the EX/MEM register; returns Data_in for latching into MEM/WB.
- Implements byte, halfword and word access with sign/zero extension.
- Detects misaligned accesses, plus sticky fault capture and load/store counters for debug.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; must be a power of two.
- CNT_W, 32, width of the load and store counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- addr  input  32  byte address (CPU Addr_out).
- din  input  32  store data (CPU Data_out); the low byte or halfword is used for sub-word stores.
- mem_w  input  1  store request.
- mem_r  input  1  load request.
- dm_type  input  3  access type: 000 word, 001 halfword, 010 halfword unsigned, 011 byte, 100 byte unsigned; 101–111 are treated as word.
- err_clr  input  1  clears the sticky fault state.
- dout  output  32  load data (CPU Data_in), combinational.
- misalign  output  1  combinational: the current access is misaligned.
- err  output  1  sticky fault flag.
- err_addr  output  32  address of the first misaligned access since the last clear.
- ld_cnt  output  CNT_W  count of completed aligned loads.
- st_cnt  output  CNT_W  count of completed aligned stores.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, rst.
- Word index: addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH*4.
- Byte lane: addr[1:0]. Halfword lane: addr[1]. Little-endian.
- Misaligned condition, only evaluated when mem_r or mem_w is high:
  - halfword types: addr[0]=1;
  - word types: addr[1:0]!=0;
  - byte accesses are never misaligned.
- Loads:
  - dout is combinational from the array. No pipeline latency: valid in the same cycle mem_r is high.
  - Byte and halfword loads select their lane, then sign-extend (types 001, 011) or zero-extend (010, 100).
  - dout=0 when mem_r=0 or the load is misaligned.
- Stores:
  - Written on the rising clk edge when mem_w=1 and the access is not misaligned.
  - Byte enables: 1111 for word; 0011 or 1100 by addr[1] for halfword; one-hot by addr[1:0] for byte.
  - Bytes outside the enabled lanes are unchanged.
  - A misaligned store writes nothing.
- mem_r and mem_w both high:
  - The store is performed.
  - dout shows pre-write contents (read-before-write).
  - Both counters increment if aligned.
- Fault capture, on an edge where misalign=1:
  - err is set to 1.
  - err_addr is loaded with addr only if err was 0 before that edge (first fault wins).
- err_clr=1 on an edge clears err and err_addr to 0. If a fault occurs on the same edge, the fault wins: err=1, err_addr=addr.
- Counters:
  - ld_cnt increments on each edge with mem_r=1 and aligned.
  - st_cnt increments on each edge with mem_w=1 and aligned.
  - Both saturate at all-ones; they do not wrap.
- Reset, edge with rst=1:
  - err=0, err_addr=0, ld_cnt=0, st_cnt=0.
  - Array contents are not cleared and no store occurs on a reset edge.
  - dout and misalign remain combinational functions of their inputs during reset.
  - err_clr is ignored while rst=1.
- Unused: no handshake or stall. Every request completes in its cycle, matching the CPU's fixed-latency MEM stage.

Test Plan:
- Word store then load: sw 0x12345678 at addr 0x10; next cycle lw 0x10 -> dout=0x12345678, st_cnt=1, ld_cnt=1.
- Sub-word stores and extended loads:
  - sb 0xAB at 0x13 over word 0x00000000; lw 0x10 -> 0xAB000000.
  - lb 0x13 -> 0xFFFFFFAB.
  - lbu 0x13 -> 0x000000AB.
  - sh 0x8001 at 0x12; lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001.
- Misalignment:
  - sw at 0x21 with word 0x20 holding 0xDEADBEEF: word unchanged, misalign=1, err=1, err_addr=0x21, st_cnt unchanged.
  - lh at 0x23 next: dout=0, err_addr stays 0x21.
- Fault clear:
  - err_clr alone -> err=0, err_addr=0.
  - err_clr together with lw at 0x06 -> err=1, err_addr=0x06.
- Wrap and simultaneous access (DEPTH=1024): sw 0xCAFEF00D at 0x1000 -> lw 0x0000 returns 0xCAFEF00D. A cycle with mem_r=mem_w=1 at 0x0 writing 0x1 shows dout=0xCAFEF00D, and the next lw returns 0x1.
- Reset and saturation (CNT_W=4):
  - 16 aligned loads -> ld_cnt=0xF, stays at 0xF.
  - rst mid-sequence -> ld_cnt, st_cnt, err all 0; previously stored data still readable.
